control_unit: RTL
=================

CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 The block SHALL have ports: clock  in  1  sole clock, all state changes on its rising edge.
REQ-002 The block SHALL have ports: reset  in  1  synchronous, active-high reset.
REQ-003 The block SHALL have ports: current_instruction  in  16  instruction latched by the datapath; opcode = [15:12], cond = [3:0].
REQ-004 The block SHALL have ports: Z_out, N_out  in  1 each  datapath zero/negative flags.
REQ-005 The block SHALL have ports: irq  in  1  level interrupt request from IO.
REQ-006 The block SHALL have ports, all out 1 bit, datapath controls: reg_write, mem_to_reg, fetch_instruction, alu_override_imm8, alu_override_imm4, alu_set_flags, set_pc, pc_from_register, pc_from_irq, mem_write, mem_write_is_stack, mem_write_next_pc, mem_write_this_pc, set_sp, increase_sp, reset_irq.
REQ-007 The block SHALL have ports: halted  out  1  high while in HALT.
REQ-008 The block SHALL have ports: in_irq  out  1  interrupt-handler-active mask.

Function
REQ-009 States SHALL be FETCH_A, FETCH_B, EXEC, LOAD_B, IRQ_PUSH, IRQ_JUMP, HALT; controls SHALL be combinational decodes of state and opcode; any control not listed for a state is 0.
REQ-010 FETCH_A: fetch_instruction=1 (address = PC, 1-cycle memory latency); next FETCH_B.
REQ-011 FETCH_B: fetch_instruction=1, instruction captured at this edge; next EXEC.
REQ-012 EXEC opcode 0x0 (ALU reg-reg): reg_write, alu_set_flags, set_pc.
REQ-013 EXEC opcode 0x1 (ALU reg-imm4): as 0x0 plus alu_override_imm4.
REQ-014 EXEC opcode 0x2 (load imm8): reg_write, alu_override_imm8, set_pc; flags untouched.
REQ-015 EXEC opcode 0x3 (load): no controls (address = r2 settles); next LOAD_B.
REQ-016 LOAD_B: mem_to_reg, reg_write, set_pc.
REQ-017 EXEC opcode 0x4 (store): mem_write, set_pc.
REQ-018 EXEC opcode 0x5 (push): mem_write, mem_write_is_stack, set_sp (increase_sp=0), set_pc.
REQ-019 EXEC opcode 0x7 (halt): no controls; next HALT; HALT is exited only by reset, ignores irq.
REQ-020 EXEC opcode 0x8 (jump): set_pc always; pc_from_register=1 iff cond taken: cond 0 always, 1 Z_out, 2 ~Z_out, 3 N_out, 4 ~N_out; cond 5-15 never taken (PC+1).
REQ-021 EXEC opcode 0x9 (call): mem_write, mem_write_is_stack, mem_write_next_pc, set_sp (decrement), set_pc, pc_from_register.
REQ-022 EXEC opcode 0xA (iret): set_pc, pc_from_register; in_irq cleared at this edge.
REQ-023 EXEC other opcodes (0x6, 0xB-0xF): set_pc only (NOP).
REQ-024 Instruction completion: after EXEC (non-0x3/0x7) or LOAD_B, next state SHALL be IRQ_PUSH if irq=1 and in_irq=0 at that edge, else FETCH_A.
REQ-025 IRQ_PUSH: mem_write, mem_write_is_stack, mem_write_this_pc, set_sp (decrement); next IRQ_JUMP.
REQ-026 IRQ_JUMP: set_pc, pc_from_register, pc_from_irq (vector r12), reset_irq=1 for exactly this cycle; in_irq set at this edge; next FETCH_A.
REQ-027 Interrupts SHALL never be taken mid-instruction or from HALT; iret followed by a pending irq SHALL re-enter IRQ_PUSH immediately (in_irq clear at that same edge counts as 0).
REQ-028 Every instruction SHALL assert set_pc in exactly one cycle; cycle counts: 3 for single-EXEC ops, 4 for load, +2 for interrupt entry.

Reset
REQ-029 With reset=1 at a rising edge, state SHALL become FETCH_A and in_irq 0; reset SHALL abort any state including IRQ_PUSH/LOAD_B/HALT.
REQ-030 While reset=1 all control outputs SHALL be 0 and halted 0; first cycle after release SHALL be FETCH_A with fetch_instruction=1.

Verification
REQ-031 Reset then instruction 0x0120 -> FETCH_A, FETCH_B, EXEC; reg_write/alu_set_flags/set_pc=1 in cycle 3 only; next FETCH_A.
REQ-032 Load 0x3120 -> EXEC with no controls, LOAD_B with mem_to_reg/reg_write/set_pc; total 4 cycles.
REQ-033 Jump 0x8101 with Z_out=0 -> set_pc=1, pc_from_register=0; with Z_out=1 -> pc_from_register=1; cond 0x7 -> never taken.
REQ-034 irq=1 during EXEC of 0x0120 -> IRQ_PUSH (mem_write, is_stack, this_pc, set_sp, increase_sp=0) then IRQ_JUMP (pc_from_irq, reset_irq one cycle), in_irq=1; second irq ignored until 0xA000 executes.
REQ-035 Halt 0x7000 with irq=1 -> HALT, halted=1, all controls 0 for 20 cycles; reset=1 -> FETCH_A next cycle.
REQ-036 reset=1 asserted in IRQ_PUSH -> next cycle FETCH_A, in_irq=0, no set_pc/set_sp pulse after the reset edge.

Source files
------------

// File: rtl/control_unit.sv
// Control unit: multi-cycle instruction sequencer for the 16-bit datapath.
// Walks each instruction through fetch, execute and (for loads) writeback,
// inserts interrupt entry between instructions, and decodes datapath controls
// combinationally from the current state and opcode.
module control_unit (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] current_instruction,
    input  logic        Z_out,
    input  logic        N_out,
    input  logic        irq,
    output logic        reg_write,
    output logic        mem_to_reg,
    output logic        fetch_instruction,
    output logic        alu_override_imm8,
    output logic        alu_override_imm4,
    output logic        alu_set_flags,
    output logic        set_pc,
    output logic        pc_from_register,
    output logic        pc_from_irq,
    output logic        mem_write,
    output logic        mem_write_is_stack,
    output logic        mem_write_next_pc,
    output logic        mem_write_this_pc,
    output logic        set_sp,
    output logic        increase_sp,
    output logic        reset_irq,
    output logic        halted,
    output logic        in_irq
);

    typedef enum logic [2:0] {
        FETCH_A,
        FETCH_B,
        EXEC,
        LOAD_B,
        IRQ_PUSH,
        IRQ_JUMP,
        HALT
    } state_t;

    state_t     r_state;
    logic       r_in_irq;
    logic [3:0] w_opcode;
    logic [3:0] w_cond;
    logic       w_iret_exec;
    logic       w_irq_take;

    // Jump condition codes; anything above 4 is never taken.
    function automatic logic cond_taken(input logic [3:0] cond, input logic z, input logic n);
        case (cond)
            4'd0:    cond_taken = 1'b1;
            4'd1:    cond_taken = z;
            4'd2:    cond_taken = ~z;
            4'd3:    cond_taken = n;
            4'd4:    cond_taken = ~n;
            default: cond_taken = 1'b0;
        endcase
    endfunction

    assign w_opcode    = current_instruction[15:12];
    assign w_cond      = current_instruction[3:0];
    // An iret clears the mask on the same edge, so a pending irq is taken right away.
    assign w_iret_exec = (r_state == EXEC) && (w_opcode == 4'hA);
    assign w_irq_take  = irq && !(r_in_irq && !w_iret_exec);
    assign in_irq      = r_in_irq;

    // Sequencer state and interrupt-active mask.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= FETCH_A;
            r_in_irq <= 1'b0;
        end else begin
            case (r_state)
                FETCH_A:  r_state <= FETCH_B;
                FETCH_B:  r_state <= EXEC;
                EXEC: begin
                    case (w_opcode)
                        4'h3:    r_state <= LOAD_B;
                        4'h7:    r_state <= HALT;
                        default: r_state <= w_irq_take ? IRQ_PUSH : FETCH_A;
                    endcase
                    if (w_opcode == 4'hA) r_in_irq <= 1'b0;
                end
                LOAD_B:   r_state <= w_irq_take ? IRQ_PUSH : FETCH_A;
                IRQ_PUSH: r_state <= IRQ_JUMP;
                IRQ_JUMP: begin
                    r_state  <= FETCH_A;
                    r_in_irq <= 1'b1;
                end
                HALT:     r_state <= HALT;
                default:  r_state <= FETCH_A;
            endcase
        end
    end

    // Datapath control decode; everything is forced low while reset is held.
    always_comb begin
        reg_write          = 1'b0;
        mem_to_reg         = 1'b0;
        fetch_instruction  = 1'b0;
        alu_override_imm8  = 1'b0;
        alu_override_imm4  = 1'b0;
        alu_set_flags      = 1'b0;
        set_pc             = 1'b0;
        pc_from_register   = 1'b0;
        pc_from_irq        = 1'b0;
        mem_write          = 1'b0;
        mem_write_is_stack = 1'b0;
        mem_write_next_pc  = 1'b0;
        mem_write_this_pc  = 1'b0;
        set_sp             = 1'b0;
        increase_sp        = 1'b0;
        reset_irq          = 1'b0;
        halted             = 1'b0;
        if (!reset) begin
            case (r_state)
                FETCH_A, FETCH_B: fetch_instruction = 1'b1;
                EXEC: begin
                    case (w_opcode)
                        4'h0: begin
                            reg_write     = 1'b1;
                            alu_set_flags = 1'b1;
                            set_pc        = 1'b1;
                        end
                        4'h1: begin
                            reg_write         = 1'b1;
                            alu_set_flags     = 1'b1;
                            alu_override_imm4 = 1'b1;
                            set_pc            = 1'b1;
                        end
                        4'h2: begin
                            reg_write         = 1'b1;
                            alu_override_imm8 = 1'b1;
                            set_pc            = 1'b1;
                        end
                        4'h3, 4'h7: begin
                        end
                        4'h4: begin
                            mem_write = 1'b1;
                            set_pc    = 1'b1;
                        end
                        4'h5: begin
                            mem_write          = 1'b1;
                            mem_write_is_stack = 1'b1;
                            set_sp             = 1'b1;
                            set_pc             = 1'b1;
                        end
                        4'h8: begin
                            set_pc           = 1'b1;
                            pc_from_register = cond_taken(w_cond, Z_out, N_out);
                        end
                        4'h9: begin
                            mem_write          = 1'b1;
                            mem_write_is_stack = 1'b1;
                            mem_write_next_pc  = 1'b1;
                            set_sp             = 1'b1;
                            set_pc             = 1'b1;
                            pc_from_register   = 1'b1;
                        end
                        4'hA: begin
                            set_pc           = 1'b1;
                            pc_from_register = 1'b1;
                        end
                        default: set_pc = 1'b1;
                    endcase
                end
                LOAD_B: begin
                    mem_to_reg = 1'b1;
                    reg_write  = 1'b1;
                    set_pc     = 1'b1;
                end
                IRQ_PUSH: begin
                    mem_write          = 1'b1;
                    mem_write_is_stack = 1'b1;
                    mem_write_this_pc  = 1'b1;
                    set_sp             = 1'b1;
                end
                IRQ_JUMP: begin
                    set_pc           = 1'b1;
                    pc_from_register = 1'b1;
                    pc_from_irq      = 1'b1;
                    reset_irq        = 1'b1;
                end
                HALT:    halted = 1'b1;
                default: begin
                end
            endcase
        end
    end

endmodule
